// File: rtl/axis_pipe_reg.sv
// axis_pipe_reg: cascade of STAGES AXI4-Stream skid-buffer register slices.
// Every stage registers both the forward path and the backward tready path, so
// long paths are cut in both directions. The block also reports how many beats
// it currently holds.
//
// Ports:
//   aclk, aresetn        clock; synchronous active-low reset
//   s_axis_*             upstream beat in (tdata/tkeep/tvalid/tlast/tid/tdest/tuser), s_axis_tready out
//   m_axis_*             downstream beat out, m_axis_tready in
//   occupancy            number of beats currently held, 0..2*STAGES
//   stall_count          cycles with m_axis_tvalid & !m_axis_tready, saturating
//                        (present only when AXIS_PIPE_REG_STATS_EN is defined)
//
// STAGES=0 turns the block into a combinational bypass.
module axis_pipe_reg #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = 1,
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int LAST_ENABLE = 0,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 0,
    parameter int USER_WIDTH  = 1,
    parameter int STAGES      = 3,
    parameter int CNT_WIDTH   = $clog2(2 * STAGES + 2)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
`ifdef AXIS_PIPE_REG_STATS_EN
    output logic [31:0]           stall_count,
    output logic [CNT_WIDTH-1:0]  occupancy
`else
    output logic [CNT_WIDTH-1:0]  occupancy
`endif
);
    // The whole beat travels as one packed payload so sidebands can never
    // separate from their data; disabled fields are replaced at the output.
    localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam int KO = DATA_WIDTH;
    localparam int LO = KO + KEEP_WIDTH;
    localparam int IO = LO + 1;
    localparam int DO = IO + ID_WIDTH;
    localparam int UO = DO + DEST_WIDTH;

    logic [PW-1:0] s_pl, m_pl;

    assign s_pl          = {s_axis_tuser, s_axis_tdest, s_axis_tid, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    assign m_axis_tdata  = m_pl[DATA_WIDTH-1:0];
    assign m_axis_tkeep  = KEEP_ENABLE != 0 ? m_pl[KO +: KEEP_WIDTH] : '1;
    assign m_axis_tlast  = LAST_ENABLE != 0 ? m_pl[LO] : 1'b1;
    assign m_axis_tid    = ID_ENABLE != 0 ? m_pl[IO +: ID_WIDTH] : '0;
    assign m_axis_tdest  = DEST_ENABLE != 0 ? m_pl[DO +: DEST_WIDTH] : '0;
    assign m_axis_tuser  = USER_ENABLE != 0 ? m_pl[UO +: USER_WIDTH] : '0;

    generate
        if (STAGES == 0) begin : g_bypass
            assign m_pl          = s_pl;
            assign m_axis_tvalid = s_axis_tvalid;
            assign s_axis_tready = m_axis_tready;
            assign occupancy     = '0;
        end else begin : g_pipe
            // chain_*[i] is the upstream side of stage i; index STAGES is m_axis.
            logic [PW-1:0] chain_d [STAGES+1];
            logic [STAGES:0] chain_v, chain_r;

            assign chain_d[0]       = s_pl;
            assign chain_v[0]       = s_axis_tvalid;
            assign chain_r[STAGES]  = m_axis_tready;
            assign m_pl             = chain_d[STAGES];
            assign m_axis_tvalid    = chain_v[STAGES];
            assign s_axis_tready    = chain_r[0];

            for (genvar i = 0; i < STAGES; i++) begin : g_stage
                logic [PW-1:0] main_d, temp_d;
                logic          main_v, temp_v, rdy;
                // rdy is registered, so a beat may arrive in the same cycle the
                // downstream stalls; the temp register catches that one beat.
                always_ff @(posedge aclk) begin
                    if (!aresetn) begin
                        main_v <= 1'b0;
                        temp_v <= 1'b0;
                        rdy    <= 1'b0;
                    end else begin
                        rdy <= chain_r[i+1] | (!temp_v & (!main_v | !chain_v[i]));
                        if (rdy) begin
                            if (chain_r[i+1] | !main_v) begin
                                main_v <= chain_v[i];
                                main_d <= chain_d[i];
                            end else begin
                                temp_v <= chain_v[i];
                                temp_d <= chain_d[i];
                            end
                        end else if (chain_r[i+1]) begin
                            main_v <= temp_v;
                            main_d <= temp_d;
                            temp_v <= 1'b0;
                        end
                    end
                end
                assign chain_d[i+1] = main_d;
                assign chain_v[i+1] = main_v;
                assign chain_r[i]   = rdy;
            end

            always_ff @(posedge aclk) begin
                if (!aresetn)
                    occupancy <= '0;
                else
                    occupancy <= occupancy + CNT_WIDTH'(s_axis_tvalid & s_axis_tready)
                                           - CNT_WIDTH'(m_axis_tvalid & m_axis_tready);
            end
        end
    endgenerate

`ifdef AXIS_PIPE_REG_STATS_EN
    always_ff @(posedge aclk) begin
        if (!aresetn)
            stall_count <= '0;
        else if (m_axis_tvalid && !m_axis_tready && stall_count != '1)
            stall_count <= stall_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_axis_pipe_reg.sv
// tb_axis_pipe_reg: randomized self-checking bench for axis_pipe_reg against a queue model.
module tb_axis_pipe_reg;
    localparam int DW  = 16;
    localparam int KW  = 2;
    localparam int IW  = 8;
    localparam int DSW = 8;
    localparam int UW  = 4;
    localparam int ST  = 3;
    localparam int CW  = $clog2(2 * ST + 2);
    localparam int PW  = DW + KW + 1 + IW + DSW + UW;

    typedef struct {
        logic [PW-1:0] pl;
        int            cyc;
    } beat_t;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic [DW-1:0]  s_tdata;
    logic [KW-1:0]  s_tkeep;
    logic           s_tvalid, s_tready, s_tlast;
    logic [IW-1:0]  s_tid;
    logic [DSW-1:0] s_tdest;
    logic [UW-1:0]  s_tuser;
    logic [DW-1:0]  m_tdata;
    logic [KW-1:0]  m_tkeep;
    logic           m_tvalid, m_tready, m_tlast;
    logic [IW-1:0]  m_tid;
    logic [DSW-1:0] m_tdest;
    logic [UW-1:0]  m_tuser;
    logic [CW-1:0]  occupancy;

    logic [DW-1:0]  z_tdata;
    logic [KW-1:0]  z_tkeep;
    logic           z_tvalid, z_tready, z_tlast;
    logic [7:0]     z_tid, z_tdest;
    logic [0:0]     z_tuser, z_occ;
`ifdef AXIS_PIPE_REG_STATS_EN
    logic [31:0]    stall_count, z_stall;
    logic [31:0]    exp_stall, exp_zstall;
`endif

    logic [PW-1:0] s_pl, m_pl;
    assign s_pl = {s_tuser, s_tdest, s_tid, s_tlast, s_tkeep, s_tdata};
    assign m_pl = {m_tuser, m_tdest, m_tid, m_tlast, m_tkeep, m_tdata};

    axis_pipe_reg #(
        .DATA_WIDTH(DW), .KEEP_ENABLE(1), .KEEP_WIDTH(KW), .LAST_ENABLE(1),
        .ID_ENABLE(1), .ID_WIDTH(IW), .DEST_ENABLE(1), .DEST_WIDTH(DSW),
        .USER_ENABLE(1), .USER_WIDTH(UW), .STAGES(ST)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
`ifdef AXIS_PIPE_REG_STATS_EN
        .stall_count(stall_count),
`endif
        .occupancy(occupancy)
    );

    axis_pipe_reg #(
        .DATA_WIDTH(DW), .KEEP_ENABLE(0), .STAGES(0)
    ) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(z_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser[0:0]),
        .m_axis_tdata(z_tdata), .m_axis_tkeep(z_tkeep), .m_axis_tvalid(z_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(z_tlast), .m_axis_tid(z_tid),
        .m_axis_tdest(z_tdest), .m_axis_tuser(z_tuser),
`ifdef AXIS_PIPE_REG_STATS_EN
        .stall_count(z_stall),
`endif
        .occupancy(z_occ)
    );

    int n_checks = 0;
    int n_errors = 0;
    beat_t q[$];
    int cyc = 0;
    int n_acc = 0;
    int n_del = 0;
    logic chk_on = 1'b0;
    logic lat_chk = 1'b0;
    logic last_s_hs = 1'b0;
    logic last_m_hs = 1'b0;
    logic prev_stall = 1'b0;
    logic [PW-1:0] prev_pl;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic new_beat();
        {s_tuser, s_tdest, s_tid, s_tlast, s_tkeep, s_tdata} = PW'({$urandom(), $urandom()});
    endtask

    // Evaluate the upcoming edge (inputs already applied), update the model,
    // then advance to the next falling edge where new inputs are applied.
    task automatic tick();
        logic s_hs, m_hs;
        beat_t e;
        #2;
        if (chk_on) begin
            check("occupancy", 64'(occupancy), 64'(q.size()));
            check("bypass_ready", 64'(z_tready), 64'(m_tready));
            check("bypass_valid", 64'(z_tvalid), 64'(s_tvalid));
            check("bypass_data", 64'(z_tdata), 64'(s_tdata));
            check("bypass_keep", 64'(z_tkeep), 64'(2'b11));
            check("bypass_last", 64'(z_tlast), 64'(1'b1));
            check("bypass_side", 64'({z_tid, z_tdest, z_tuser}), 64'(0));
            check("bypass_occ", 64'(z_occ), 64'(0));
`ifdef AXIS_PIPE_REG_STATS_EN
            check("stall_count", 64'(stall_count), 64'(exp_stall));
            check("bypass_stall", 64'(z_stall), 64'(exp_zstall));
`endif
        end
        if (!aresetn) begin
            q.delete();
            prev_stall = 1'b0;
            last_s_hs  = 1'b0;
            last_m_hs  = 1'b0;
`ifdef AXIS_PIPE_REG_STATS_EN
            exp_stall  = 0;
            exp_zstall = 0;
`endif
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(m_tvalid), 64'(1'b1));
                check("hold_data", 64'(m_pl), 64'(prev_pl));
            end
            s_hs = s_tvalid & s_tready;
            m_hs = m_tvalid & m_tready;
            if (m_hs) begin
                if (q.size() == 0) begin
                    check("spurious_beat", 64'(m_hs), 64'(0));
                end else begin
                    e = q.pop_front();
                    check("beat", 64'(m_pl), 64'(e.pl));
                    if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'(ST));
                    n_del++;
                end
            end
            if (s_hs) begin
                q.push_back('{s_pl, cyc});
                n_acc++;
            end
            prev_stall = m_tvalid & !m_tready;
            prev_pl    = m_pl;
            last_s_hs  = s_hs;
            last_m_hs  = m_hs;
`ifdef AXIS_PIPE_REG_STATS_EN
            if (prev_stall && exp_stall != 32'hFFFF_FFFF) exp_stall++;
            if (s_tvalid && !m_tready && exp_zstall != 32'hFFFF_FFFF) exp_zstall++;
`endif
        end
        cyc++;
        @(negedge aclk);
    endtask

    initial begin
        int base, guard;
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        new_beat();
        tick();
        chk_on = 1'b1;
        repeat (2) tick();
        check("rst_s_ready", 64'(s_tready), 64'(0));
        check("rst_m_valid", 64'(m_tvalid), 64'(0));
        check("rst_occ", 64'(occupancy), 64'(0));
        aresetn = 1'b1;
        check("ready_before_edge", 64'(s_tready), 64'(0));
        tick();
        check("ready_after_edge", 64'(s_tready), 64'(1));

        // back-to-back 0x01..0x10 with no backpressure
        lat_chk = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            new_beat();
            s_tdata  = DW'(i);
            s_tvalid = 1'b1;
            if (i == 8) check("steady_occ", 64'(occupancy), 64'(3));
            tick();
            check("b2b_accept", 64'(last_s_hs), 64'(1));
        end
        s_tvalid = 1'b0;
        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        check("b2b_delivered", 64'(n_del), 64'(16));
        lat_chk = 1'b0;

        // fill under backpressure, then drain without bubbles
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        new_beat();
        base = n_acc;
        repeat (12) begin
            tick();
            if (last_s_hs) new_beat();
        end
        s_tvalid = 1'b0;
        check("fill_count", 64'(n_acc - base), 64'(6));
        check("fill_ready", 64'(s_tready), 64'(0));
        check("fill_occ", 64'(occupancy), 64'(6));
        m_tready = 1'b1;
        repeat (6) begin
            tick();
            check("no_bubble", 64'(last_m_hs), 64'(1));
        end
        check("drain_occ", 64'(occupancy), 64'(0));

        // random valid/ready
        base  = n_acc;
        guard = 0;
        while (n_acc - base < 10000 && guard < 60000) begin
            m_tready = 1'($urandom_range(0, 1));
            if (!(s_tvalid && !last_s_hs)) begin
                s_tvalid = 1'($urandom_range(0, 1));
                new_beat();
            end
            tick();
            guard++;
        end
        check("rand_timeout", 64'(guard < 60000), 64'(1));
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int k = 0; k < 50 && q.size() != 0; k++) tick();
        check("rand_drain_occ", 64'(occupancy), 64'(0));
        check("rand_count", 64'(n_del), 64'(n_acc));

        // reset while holding 4 beats
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        new_beat();
        base = n_acc;
        for (int k = 0; k < 20 && n_acc - base < 4; k++) begin
            tick();
            if (last_s_hs) new_beat();
        end
        s_tvalid = 1'b0;
        tick();
        check("pre_reset_occ", 64'(occupancy), 64'(4));
        aresetn = 1'b0;
        tick();
        check("mid_rst_valid", 64'(m_tvalid), 64'(0));
        check("mid_rst_occ", 64'(occupancy), 64'(0));
        check("mid_rst_ready", 64'(s_tready), 64'(0));
        aresetn  = 1'b1;
        m_tready = 1'b1;
        base = n_del;
        repeat (10) tick();
        check("no_stale", 64'(n_del - base), 64'(0));

`ifdef AXIS_PIPE_REG_STATS_EN
        aresetn = 1'b0;
        tick();
        aresetn  = 1'b1;
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        new_beat();
        tick();
        s_tvalid = 1'b0;
        for (int k = 0; k < 10 && !m_tvalid; k++) tick();
        repeat (20) tick();
        check("stall_20", 64'(stall_count), 64'(20));
        m_tready = 1'b1;
        repeat (5) tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
